gcd_mod_seq: RTL and testbench
==============================

# gcd_mod_seq

Euclidean GCD sequencer. It drives one external multi-cycle mod unit (run/ready handshake, A mod B) to compute gcd(op_a, op_b). The block issues one mod operation per Euclid step and handles the degenerate steps locally: swaps, zero divisor, and divisor MSB set, which the mod unit must never receive. It sits between the requesting datapath and the mod unit; both share clk and resetn.

## Interface
- WD_CYCLES, 128: watchdog limit in cycles spent in WAIT; used only with GCD_WDOG_EN.
- Reset resetn, asynchronous, active-low; clock clk.
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op_a  in  32  first operand, latched with start
- op_b  in  32  second operand, latched with start
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse in DONE
- gcd  out  32  result; valid from DONE, held until next accepted start
- iter  out  6  count of Euclid remainder steps (mod-unit and local), saturates at 63
- err  out  1  watchdog abort flag, valid with done; constant 0 without GCD_WDOG_EN
- mod_run  out  1  one-cycle pulse to mod unit
- mod_a  out  32  dividend, driven continuously from register x
- mod_b  out  32  divisor, driven continuously from register y
- mod_result  in  32  mod unit remainder
- mod_ready  in  1  mod unit result valid (level)

## Operation
- Registers: x, y (32 b), iter (6 b), state.
- IDLE: on start, latch x=op_a, y=op_b, iter=0, err=0; go to CHECK.
- CHECK, priority order:
  - y==0: gcd<=x; go to DONE.
  - x<y: swap x and y; stay in CHECK; iter unchanged.
  - y[31]==1: local step. Since x>=y and y>=2^31, x mod y = x−y. Set x<=y, y<=x−y, iter++; stay in CHECK.
  - Otherwise: go to ISSUE.
- ISSUE: mod_run=1; go to ARM.
- ARM: ignore mod_ready; the mod unit is loading and its stale ready drops this cycle. Go to WAIT.
- WAIT: on mod_ready, set x<=y, y<=mod_result, iter++ (saturating); go to CHECK.
- DONE: done=1; go to IDLE.
- mod_a/mod_b must stay stable from ISSUE through WAIT. This holds by construction, because x and y do not change in those states.
- start is ignored while busy. gcd(0,0) returns 0 with iter=0.

## Timing
- Reset values: busy=0, done=0, gcd=0, iter=0, err=0, mod_run=0, x=y=0, state=IDLE.
- resetn asserted mid-operation aborts immediately. There is no done pulse, and the next start after release runs normally.
- y==0 at start: start in cycle t, CHECK at t+1, done at t+2.
- Each swap or local step costs 1 cycle.
- Each mod step costs 3 cycles (CHECK, ISSUE, ARM) plus the WAIT cycles up to and including the one where mod_ready is seen.
- done is never asserted in the same cycle that start is accepted.

## Configuration
- GCD_WDOG_EN defined:
  - A counter clears on entry to ARM and increments each cycle in WAIT.
  - When it reaches WD_CYCLES with mod_ready low: err=1, gcd=0; go to DONE.
  - The mod unit is not reset by this block; the parent handles recovery.
- GCD_WDOG_EN undefined: no counter; err is tied 0; WAIT waits indefinitely.

## Structure
- Package gcd_pkg holds:
  - state enum: IDLE, CHECK, ISSUE, ARM, WAIT, DONE
  - DATA_W=32
  - ITER_W=6
  - ITER_MAX=63
- Sub-module gcd_wdog holds the watchdog counter and is instantiated only under GCD_WDOG_EN.
- The mod unit is instantiated by the parent, not inside this block.

## Test plan
- gcd(48,18) -> mod calls (48,18)=12, (18,12)=6, (12,6)=0; gcd=6, iter=3, exactly 3 mod_run pulses.
- gcd(0,0) and gcd(25,0) -> gcd=0 and 25; done at t+2; mod_run never asserted.
- gcd(7,35) -> one swap, then mod(35,7)=0; gcd=7, iter=1.
- gcd(0xFFFFFFFF,0x80000000) -> local step gives y=0x7FFFFFFF with no mod_run. Then mod(0x80000000,0x7FFFFFFF)=1 and mod(0x7FFFFFFF,1)=0; gcd=1, iter=3.
- start pulsed during WAIT is ignored and operands are unchanged. resetn low in WAIT drives all outputs to 0. A following gcd(12,8) returns 4.
- Bench mod model holds mod_ready low:
  - With GCD_WDOG_EN and WD_CYCLES=128: done with err=1, gcd=0, 128 cycles after ARM.
  - Without GCD_WDOG_EN: busy stays 1.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and sizing for the Euclidean GCD sequencer.
package gcd_pkg;

   localparam int DATA_W   = 32;
   localparam int ITER_W   = 6;
   localparam int ITER_MAX = 63;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      ISSUE,
      ARM,
      WAIT,
      DONE
   } state_t;

endpackage

// File: rtl/gcd_wdog.sv
// Watchdog for the WAIT state of gcd_mod_seq: counts cycles spent waiting
// on the mod unit and flags the cycle in which the limit is reached.
// Only instantiated when GCD_WDOG_EN is defined.
module gcd_wdog #(
   parameter int WD_CYCLES = 128
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear,     // high in the cycle before ARM
   input  logic active,    // high while the sequencer sits in WAIT
   output logic expired    // this WAIT cycle brings the count to WD_CYCLES
);

   localparam int CNT_W = $clog2(WD_CYCLES + 1);

   logic [CNT_W-1:0] cnt;

   // Wait-cycle counter, cleared on the way into ARM, saturating at the limit.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (active && (cnt != CNT_W'(WD_CYCLES))) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = active && (cnt == CNT_W'(WD_CYCLES - 1));

endmodule

// File: rtl/gcd_mod_seq.sv
// Euclidean GCD sequencer driving an external multi-cycle mod unit.
// Swaps, zero divisors and divisors with the MSB set are handled locally, so
// the mod unit only ever sees 0 < mod_b < 2^31.
// Optional feature: define GCD_WDOG_EN to build the WAIT-state watchdog
// (abort after WD_CYCLES cycles in WAIT with err=1, gcd=0).
module gcd_mod_seq
   import gcd_pkg::*;
#(
   parameter int WD_CYCLES = 128
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] gcd,
   output logic [ITER_W-1:0] iter,
   output logic              err,
   output logic              mod_run,
   output logic [DATA_W-1:0] mod_a,
   output logic [DATA_W-1:0] mod_b,
   input  logic [DATA_W-1:0] mod_result,
   input  logic              mod_ready
);

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   x, y, gcd_q;
   logic [ITER_W-1:0]   iter_q, iter_inc;
   logic                y_zero, x_lt_y, y_msb;
   logic                timeout;

   assign y_zero   = (y == '0);
   assign x_lt_y   = (x < y);
   assign y_msb    = y[DATA_W-1];
   assign iter_inc = (iter_q == ITER_W'(ITER_MAX)) ? iter_q : iter_q + 1'b1;

`ifdef GCD_WDOG_EN
   logic err_q;

   gcd_wdog #(.WD_CYCLES(WD_CYCLES)) u_wdog (
      .clk     (clk),
      .resetn  (resetn),
      .clear   (state == ISSUE),
      .active  (state == WAIT),
      .expired (timeout)
   );

   // Abort flag: cleared by an accepted start, set when the watchdog fires.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         err_q <= 1'b0;
      end else if ((state == IDLE) && start) begin
         err_q <= 1'b0;
      end else if ((state == WAIT) && !mod_ready && timeout) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   // WD_CYCLES only has an effect when the watchdog is built.
   logic unused_wd_cycles;
   assign unused_wd_cycles = (WD_CYCLES > 0);
   assign timeout          = 1'b0;
   assign err              = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic; WAIT gives mod_ready priority over the watchdog.
   // NOTE: default assigned first so no path through the case leaves
   // state_nxt unassigned and infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CHECK;
         CHECK: begin
            if (y_zero)                 state_nxt = DONE;
            else if (x_lt_y || y_msb)   state_nxt = CHECK;
            else                        state_nxt = ISSUE;
         end
         ISSUE:   state_nxt = ARM;
         ARM:     state_nxt = WAIT;
         WAIT: begin
            if (mod_ready)    state_nxt = CHECK;
            else if (timeout) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Euclid datapath: operand latch, swap, local MSB step, mod-unit step.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x      <= '0;
         y      <= '0;
         iter_q <= '0;
         gcd_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  x      <= op_a;
                  y      <= op_b;
                  iter_q <= '0;
               end
            end
            CHECK: begin
               if (y_zero) begin
                  gcd_q <= x;
               end else if (x_lt_y) begin
                  x <= y;
                  y <= x;
               end else if (y_msb) begin
                  // x >= y >= 2^31, so x mod y is a single subtraction.
                  x      <= y;
                  y      <= x - y;
                  iter_q <= iter_inc;
               end
            end
            WAIT: begin
               if (mod_ready) begin
                  x      <= y;
                  y      <= mod_result;
                  iter_q <= iter_inc;
               end else if (timeout) begin
                  gcd_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   assign mod_run = (state == ISSUE);
   assign mod_a   = x;
   assign mod_b   = y;
   assign gcd     = gcd_q;
   assign iter    = iter_q;

endmodule

// File: tb/tb_gcd_mod_seq.sv
// Self-checking bench for gcd_mod_seq: directed cases, randomized operands,
// a behavioural mod unit with random latency, and a scoreboard monitor.
module tb_gcd_mod_seq;
   import gcd_pkg::*;

   localparam int WD = 128;

   typedef struct {
      logic [31:0] gcd;
      logic [5:0]  iter;
      logic        err;
      int          nmod;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn, start;
   logic [31:0] op_a, op_b;
   logic        busy, done, err, mod_run, mod_ready;
   logic [31:0] gcd, mod_a, mod_b, mod_result;
   logic [5:0]  iter;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // mod unit model controls and state
   bit          hang = 1'b0;
   int          lat_lo = 0, lat_hi = 3;
   bit          pending = 1'b0, arm_seen = 1'b0, drop_req = 1'b0;
   int          lat_left = 0;
   logic [31:0] la, lb;
   int          mod_cnt = 0;

   always #5 clk = ~clk;

   gcd_mod_seq #(.WD_CYCLES(WD)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .op_a       (op_a),
      .op_b       (op_b),
      .busy       (busy),
      .done       (done),
      .gcd        (gcd),
      .iter       (iter),
      .err        (err),
      .mod_run    (mod_run),
      .mod_a      (mod_a),
      .mod_b      (mod_b),
      .mod_result (mod_result),
      .mod_ready  (mod_ready)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Plain Euclid: a remainder step is counted whether it is local or goes to
   // the mod unit; divisors with bit 31 set never reach the mod unit.
   function automatic exp_t ref_gcd(input logic [31:0] a, input logic [31:0] b);
      exp_t            e;
      longint unsigned u, v, t;
      int              steps, mods;
      u = a; v = b; steps = 0; mods = 0;
      while (v != 0) begin
         if (u < v) begin
            t = u; u = v; v = t;
         end else begin
            if (v < 64'h8000_0000) mods++;
            t = u % v; u = v; v = t;
            steps++;
         end
      end
      e.gcd  = u[31:0];
      e.iter = (steps > 63) ? 6'd63 : 6'(steps);
      e.err  = 1'b0;
      e.nmod = mods;
      return e;
   endfunction

   // Behavioural mod unit: ready stays up (stale) through ARM, drops just
   // after the edge leaving ARM, then rises after a random latency.
   always @(negedge clk) begin
      if (!resetn) begin
         pending = 1'b0; arm_seen = 1'b0; drop_req = 1'b0;
         mod_ready = 1'b0; mod_result = '0;
      end else if (mod_run) begin
         la = mod_a; lb = mod_b;
         check("mod_b_legal", 64'((lb == 0) || lb[31]), 64'd0);
         pending  = 1'b1;
         arm_seen = 1'b0;
         lat_left = $urandom_range(lat_hi, lat_lo);
      end else if (pending) begin
         check("mod_a_stable", 64'(mod_a), 64'(la));
         check("mod_b_stable", 64'(mod_b), 64'(lb));
         if (!arm_seen) begin
            arm_seen = 1'b1;
            drop_req = 1'b1;
         end else if (!hang) begin
            if (lat_left == 0) begin
               mod_result = (lb == 0) ? 32'd0 : la % lb;
               mod_ready  = 1'b1;
               pending    = 1'b0;
            end else begin
               lat_left--;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (drop_req) begin
         mod_ready = 1'b0;
         drop_req  = 1'b0;
      end
   end

   // Scoreboard monitor: every done pulse pops one expected result.
   always @(negedge clk) begin
      exp_t e;
      if (!resetn) begin
         mod_cnt = 0;
      end else begin
         if (mod_run) mod_cnt++;
         if (done) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", 64'(done), 64'd0);
            end else begin
               e = sb_q.pop_front();
               check("gcd",      64'(gcd),     64'(e.gcd));
               check("iter",     64'(iter),    64'(e.iter));
               check("err",      64'(err),     64'(e.err));
               check("mod_runs", 64'(mod_cnt), 64'(e.nmod));
            end
            mod_cnt = 0;
         end
      end
   end

   task automatic issue_raw(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op_a = a; op_b = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      sb_q.push_back(ref_gcd(a, b));
      issue_raw(a, b);
   endtask

   // Returns with lat = cycle of done relative to the start cycle t.
   task automatic wait_done(input int budget, output int lat);
      lat = 1;
      while (!done && lat < budget) begin
         @(negedge clk);
         lat++;
      end
      check("done_seen", 64'(done), 64'd1);
   endtask

   task automatic wait_mod_run(input int budget);
      int k;
      k = 0;
      while (!mod_run && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("mod_run_seen", 64'(mod_run), 64'd1);
   endtask

   task automatic check_outs_zero(input string tag);
      check({tag, "_busy"},    64'(busy),    64'd0);
      check({tag, "_done"},    64'(done),    64'd0);
      check({tag, "_gcd"},     64'(gcd),     64'd0);
      check({tag, "_iter"},    64'(iter),    64'd0);
      check({tag, "_err"},     64'(err),     64'd0);
      check({tag, "_mod_run"}, 64'(mod_run), 64'd0);
      check({tag, "_mod_a"},   64'(mod_a),   64'd0);
      check({tag, "_mod_b"},   64'(mod_b),   64'd0);
   endtask

   initial begin
      #900_000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "global timeout");
   end

   initial begin
      int          lat, n;
      logic [31:0] a, b;
      resetn = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
      repeat (2) @(negedge clk);
      check_outs_zero("reset");
      resetn = 1'b1;
      @(negedge clk);

      // Zero divisor: done two cycles after the start cycle, no mod_run.
      issue(32'd0, 32'd0);   wait_done(20, lat); check("lat_0_0",  64'(lat), 64'd2);
      issue(32'd25, 32'd0);  wait_done(20, lat); check("lat_25_0", 64'(lat), 64'd2);
      issue(32'd48, 32'd18); wait_done(200, lat);
      issue(32'd7, 32'd35);  wait_done(200, lat);
      issue(32'hFFFF_FFFF, 32'h8000_0000); wait_done(200, lat);
      issue(32'd2971215073, 32'd1836311903); wait_done(2000, lat);

      // start during WAIT must be ignored.
      lat_lo = 5; lat_hi = 5;
      issue(32'd48, 32'd18);
      wait_mod_run(50);
      repeat (2) @(negedge clk);
      op_a = 32'd99; op_b = 32'd11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(200, lat);

      // Reset in WAIT aborts with no done; next operation runs normally.
      issue(32'd48, 32'd18);
      wait_mod_run(50);
      repeat (2) @(negedge clk);
      resetn = 1'b0;
      #1;
      check_outs_zero("abort");
      sb_q.delete();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      lat_lo = 0; lat_hi = 4;
      issue(32'd12, 32'd8); wait_done(200, lat);

      // Randomized operands.
      for (int i = 0; i < 40; i++) begin
         a = $urandom; b = $urandom;
         case ($urandom_range(3, 0))
            0: ;
            1: begin a = a & 32'hFF; b = b & 32'hFF; end
            2: begin a = a | 32'h8000_0000; b = b | 32'h8000_0000; end
            default: if (a[0]) b = '0; else a = '0;
         endcase
         issue(a, b);
         wait_done(3000, lat);
      end

      // Mod unit never becomes ready.
      hang = 1'b1;
      issue_raw(32'd48, 32'd18);
      wait_mod_run(50);
`ifdef GCD_WDOG_EN
      sb_q.push_back('{gcd: 32'd0, iter: 6'd0, err: 1'b1, nmod: 1});
      @(negedge clk);              // ARM
      n = 0;
      while (!done && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("wdog_wait_cycles", 64'(n - 1), 64'(WD));
`else
      n = 0;
      repeat (400) @(negedge clk);
      check("hang_busy", 64'(busy), 64'd1);
`endif
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      hang = 1'b0;
      resetn = 1'b1;
      issue(32'd12, 32'd8); wait_done(200, lat);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
